// File: rtl/dpi_call_arbiter.sv
// dpi_call_arbiter: round-robin sharing of one host DPI call channel among NUM_REQ call sites.
// Optional watchdog on the host return is enabled by defining LOOM_DPI_TIMEOUT_EN.
module dpi_call_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int FUNC_ID_W      = 8,
  parameter int ARG_W          = 128,
  parameter int RET_W          = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*FUNC_ID_W-1:0] req_func_id_i,
  input  logic [NUM_REQ*ARG_W-1:0]     req_args_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic [NUM_REQ-1:0]           rsp_valid_o,
  output logic [RET_W-1:0]             rsp_ret_o,
  output logic                         host_call_valid_o,
  input  logic                         host_call_ready_i,
  output logic [FUNC_ID_W-1:0]         host_call_func_id_o,
  output logic [ARG_W-1:0]             host_call_args_o,
  output logic [$clog2(NUM_REQ)-1:0]   host_call_src_o,
  input  logic                         host_ret_valid_i,
  input  logic [RET_W-1:0]             host_ret_data_i,
  output logic                         stall_o,
  output logic [31:0]                  call_count_o,
  output logic                         err_timeout_o
);
  localparam int SW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;
  state_t state;
  logic [SW-1:0] ptr, gnt;
  logic any, tmo;
  int j;
  // Later loop iterations overwrite earlier ones, so the lowest offset from ptr+1 wins.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    j = 0;
    for (int k = NUM_REQ; k > 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req_valid_i[j[SW-1:0]]) begin
        gnt = j[SW-1:0];
        any = 1'b1;
      end
    end
  end
  assign req_ready_o = (state == S_IDLE && any) ? NUM_REQ'(1) << gnt : '0;
`ifdef LOOM_DPI_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic err_q;
  assign tmo = tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign err_timeout_o = err_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else if (state != S_WAIT) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
      if (tmo && !host_ret_valid_i) err_q <= 1'b1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign tmo = 1'b0;
  assign err_timeout_o = 1'b0;
`endif
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state               <= S_IDLE;
      ptr                 <= SW'(NUM_REQ - 1);
      host_call_valid_o   <= 1'b0;
      host_call_func_id_o <= '0;
      host_call_args_o    <= '0;
      host_call_src_o     <= '0;
      rsp_valid_o         <= '0;
      rsp_ret_o           <= '0;
      stall_o             <= 1'b0;
      call_count_o        <= '0;
    end else begin
      case (state)
        S_IDLE: if (any) begin
          state               <= S_ISSUE;
          ptr                 <= gnt;
          host_call_src_o     <= gnt;
          host_call_func_id_o <= req_func_id_i[gnt*FUNC_ID_W +: FUNC_ID_W];
          host_call_args_o    <= req_args_i[gnt*ARG_W +: ARG_W];
          host_call_valid_o   <= 1'b1;
          stall_o             <= 1'b1;
        end
        S_ISSUE: if (host_call_ready_i) begin
          state             <= S_WAIT;
          host_call_valid_o <= 1'b0;
        end
        S_WAIT: if (host_ret_valid_i || tmo) begin
          state        <= S_RESPOND;
          rsp_valid_o  <= NUM_REQ'(1) << host_call_src_o;
          rsp_ret_o    <= host_ret_valid_i ? host_ret_data_i : '1;
          call_count_o <= call_count_o + 1'b1;
        end
        S_RESPOND: begin
          state       <= S_IDLE;
          rsp_valid_o <= '0;
          stall_o     <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dpi_call_arbiter.sv
// tb_dpi_call_arbiter: scenario tasks with a response scoreboard for dpi_call_arbiter.
module tb_dpi_call_arbiter;
  localparam int N = 4, FW = 8, AW = 128, RW = 32;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic [N-1:0] req_valid_i = '0;
  logic [N*FW-1:0] req_func_id_i = '0;
  logic [N*AW-1:0] req_args_i = '0;
  logic [N-1:0] req_ready_o, rsp_valid_o;
  logic [RW-1:0] rsp_ret_o;
  logic host_call_valid_o, host_call_ready_i = 1'b0;
  logic [FW-1:0] host_call_func_id_o;
  logic [AW-1:0] host_call_args_o;
  logic [1:0] host_call_src_o;
  logic host_ret_valid_i = 1'b0;
  logic [RW-1:0] host_ret_data_i = '0;
  logic stall_o, err_timeout_o;
  logic [31:0] call_count_o;
  int checks = 0, errors = 0;
  typedef struct {logic [N-1:0] oh; logic [RW-1:0] ret;} exp_t;
  exp_t q[$];
  exp_t e;

  dpi_call_arbiter #(.NUM_REQ(N), .FUNC_ID_W(FW), .ARG_W(AW), .RET_W(RW), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_func_id_i(req_func_id_i),
    .req_args_i(req_args_i), .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_ret_o(rsp_ret_o),
    .host_call_valid_o(host_call_valid_o), .host_call_ready_i(host_call_ready_i),
    .host_call_func_id_o(host_call_func_id_o), .host_call_args_o(host_call_args_o),
    .host_call_src_o(host_call_src_o), .host_ret_valid_i(host_ret_valid_i),
    .host_ret_data_i(host_ret_data_i), .stall_o(stall_o), .call_count_o(call_count_o),
    .err_timeout_o(err_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  always @(negedge clk_i) if (rst_ni && rsp_valid_o !== '0) begin
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL rsp_unexpected got valid %b ret %h exp none", rsp_valid_o, rsp_ret_o);
    end else begin
      e = q.pop_front();
      if ({rsp_valid_o, rsp_ret_o} !== {e.oh, e.ret}) begin
        errors++;
        $display("FAIL rsp got valid %b ret %h exp valid %b ret %h", rsp_valid_o, rsp_ret_o, e.oh, e.ret);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_valid_i = '0;
    host_call_ready_i = 1'b0;
    host_ret_valid_i = 1'b0;
    repeat (2) tick();
    rst_ni = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge clk_i);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending exp 0", name, q.size());
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({req_ready_o, rsp_valid_o, rsp_ret_o, host_call_valid_o, host_call_func_id_o, host_call_args_o,
         host_call_src_o, stall_o, call_count_o, err_timeout_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got nonzero exp 0 (stall %b count %h)", stall_o, call_count_o);
    end
    tick();
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({req_ready_o, host_call_valid_o, stall_o, call_count_o} !== '0) begin
      errors++;
      $display("FAIL reset_idle got ready %b hv %b stall %b count %h exp 0", req_ready_o, host_call_valid_o, stall_o, call_count_o);
    end
  endtask

  task automatic test_single();
    tick();
    req_func_id_i[7:0] = 8'h03;
    req_args_i[127:0] = {96'h0, 32'hCAFE};
    req_valid_i = 4'b0001;
    @(negedge clk_i);
    checks++;
    if (req_ready_o !== 4'b0001) begin
      errors++;
      $display("FAIL single_ready got %b exp 0001", req_ready_o);
    end
    q.push_back('{4'b0001, 32'hDAFE});
    tick();
    req_valid_i = '0;
    host_call_ready_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({host_call_valid_o, host_call_src_o, host_call_func_id_o, host_call_args_o[31:0], stall_o, req_ready_o} !==
        {1'b1, 2'd0, 8'h03, 32'hCAFE, 1'b1, 4'b0}) begin
      errors++;
      $display("FAIL single_issue got v %b src %0d id %h args %h stall %b exp 1 0 03 0000cafe 1",
               host_call_valid_o, host_call_src_o, host_call_func_id_o, host_call_args_o[31:0], stall_o);
    end
    tick();
    host_call_ready_i = 1'b0;
    host_ret_valid_i = 1'b1;
    host_ret_data_i = 32'hDAFE;
    @(negedge clk_i);
    checks++;
    if ({host_call_valid_o, stall_o, rsp_valid_o} !== {1'b0, 1'b1, 4'b0}) begin
      errors++;
      $display("FAIL single_wait got hv %b stall %b rsp %b exp 0 1 0000", host_call_valid_o, stall_o, rsp_valid_o);
    end
    tick();
    host_ret_valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({call_count_o, stall_o, rsp_valid_o} !== {32'd1, 1'b1, 4'b0001}) begin
      errors++;
      $display("FAIL single_respond got count %0d stall %b rsp %b exp 1 1 0001", call_count_o, stall_o, rsp_valid_o);
    end
    tick();
    @(negedge clk_i);
    checks++;
    if ({stall_o, rsp_valid_o, rsp_ret_o} !== {1'b0, 4'b0, 32'hDAFE}) begin
      errors++;
      $display("FAIL single_after got stall %b rsp %b ret %h exp 0 0000 0000dafe", stall_o, rsp_valid_o, rsp_ret_o);
    end
  endtask

  task automatic test_round_robin();
    int n = 0;
    logic hs;
    logic [1:0] s;
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_func_id_i[i*FW +: FW] = FW'(8'h10 + i);
      req_args_i[i*AW +: AW] = AW'(i * 17);
    end
    for (int i = 0; i < 6; i++) q.push_back('{4'(1) << (i % 4), 32'h100 + 32'(i % 4)});
    req_valid_i = 4'hF;
    host_call_ready_i = 1'b1;
    for (int c = 0; c < 200 && !(n == 6 && q.size() == 0); c++) begin
      @(negedge clk_i);
      if (req_ready_o !== '0) begin
        checks++;
        if (req_ready_o !== 4'(1) << (n % 4)) begin
          errors++;
          $display("FAIL rr_grant%0d got %b exp %b", n, req_ready_o, 4'(1) << (n % 4));
        end
        n++;
      end
      hs = host_call_valid_o && host_call_ready_i;
      s = host_call_src_o;
      tick();
      host_ret_valid_i = hs;
      host_ret_data_i = 32'h100 + 32'(s);
      if (n == 6) req_valid_i = '0;
    end
    host_ret_valid_i = 1'b0;
    host_call_ready_i = 1'b0;
    req_valid_i = '0;
    checks++;
    if (n != 6 || q.size() != 0 || call_count_o !== 32'd6) begin
      errors++;
      $display("FAIL rr_done got grants %0d pending %0d count %0d exp 6 0 6", n, q.size(), call_count_o);
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] a = {$urandom, $urandom, $urandom, $urandom};
    tick();
    req_func_id_i[1*FW +: FW] = 8'h5A;
    req_args_i[1*AW +: AW] = a;
    req_valid_i = 4'b0010;
    @(negedge clk_i);
    checks++;
    if (req_ready_o !== 4'b0010) begin
      errors++;
      $display("FAIL bp_ready got %b exp 0010", req_ready_o);
    end
    q.push_back('{4'b0010, 32'h1234});
    tick();
    req_valid_i = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checks++;
      if ({host_call_valid_o, host_call_func_id_o, host_call_args_o, host_call_src_o, rsp_valid_o} !==
          {1'b1, 8'h5A, a, 2'd1, 4'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d got v %b id %h src %0d rsp %b exp 1 5a 1 0000", i, host_call_valid_o,
                 host_call_func_id_o, host_call_src_o, rsp_valid_o);
      end
      tick();
    end
    host_call_ready_i = 1'b1;
    tick();
    host_call_ready_i = 1'b0;
    host_ret_valid_i = 1'b1;
    host_ret_data_i = 32'h1234;
    tick();
    host_ret_valid_i = 1'b0;
    wait_drain("bp");
  endtask

  task automatic test_spurious();
    logic [31:0] cnt;
    tick();
    cnt = call_count_o;
    host_ret_valid_i = 1'b1;
    host_ret_data_i = 32'h77;
    tick();
    host_ret_valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({rsp_valid_o, call_count_o, stall_o} !== {4'b0, cnt, 1'b0}) begin
      errors++;
      $display("FAIL sp_idle got rsp %b count %0d stall %b exp 0000 %0d 0", rsp_valid_o, call_count_o, stall_o, cnt);
    end
    tick();
    req_valid_i = 4'b1000;
    tick();
    req_valid_i = '0;
    host_call_ready_i = 1'b1;
    host_ret_valid_i = 1'b1;
    host_ret_data_i = 32'h99;
    tick();
    host_call_ready_i = 1'b0;
    host_ret_valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({rsp_valid_o, call_count_o, stall_o} !== {4'b0, cnt, 1'b1}) begin
      errors++;
      $display("FAIL sp_issue got rsp %b count %0d stall %b exp 0000 %0d 1", rsp_valid_o, call_count_o, stall_o, cnt);
    end
    q.push_back('{4'b1000, 32'h42});
    tick();
    host_ret_valid_i = 1'b1;
    host_ret_data_i = 32'h42;
    tick();
    host_ret_valid_i = 1'b0;
    wait_drain("sp");
    checks++;
    if (call_count_o !== cnt + 1) begin
      errors++;
      $display("FAIL sp_count got %0d exp %0d", call_count_o, cnt + 1);
    end
  endtask

  task automatic test_reset_mid_wait();
    tick();
    req_valid_i = 4'b0001;
    tick();
    req_valid_i = '0;
    host_call_ready_i = 1'b1;
    tick();
    host_call_ready_i = 1'b0;
    tick();
    rst_ni = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({req_ready_o, rsp_valid_o, rsp_ret_o, host_call_valid_o, host_call_func_id_o, host_call_args_o,
         host_call_src_o, stall_o, call_count_o, err_timeout_o} !== '0) begin
      errors++;
      $display("FAIL rmw_outputs got nonzero exp 0 (stall %b count %0d)", stall_o, call_count_o);
    end
    tick();
    rst_ni = 1'b1;
    req_func_id_i[2*FW +: FW] = 8'hE2;
    req_valid_i = 4'b0100;
    @(negedge clk_i);
    checks++;
    if ({req_ready_o, call_count_o} !== {4'b0100, 32'd0}) begin
      errors++;
      $display("FAIL rmw_grant got ready %b count %0d exp 0100 0", req_ready_o, call_count_o);
    end
    q.push_back('{4'b0100, 32'h55});
    tick();
    req_valid_i = '0;
    host_call_ready_i = 1'b1;
    tick();
    host_call_ready_i = 1'b0;
    host_ret_valid_i = 1'b1;
    host_ret_data_i = 32'h55;
    tick();
    host_ret_valid_i = 1'b0;
    wait_drain("rmw");
    checks++;
    if (call_count_o !== 32'd1) begin
      errors++;
      $display("FAIL rmw_count got %0d exp 1", call_count_o);
    end
  endtask

`ifdef LOOM_DPI_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req_valid_i = 4'b0010;
    tick();
    req_valid_i = '0;
    host_call_ready_i = 1'b1;
    tick();
    host_call_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      checks++;
      if ({err_timeout_o, rsp_valid_o} !== 5'b0) begin
        errors++;
        $display("FAIL to_wait%0d got err %b rsp %b exp 0 0000", i, err_timeout_o, rsp_valid_o);
      end
      if (i == 15) q.push_back('{4'b0010, 32'hFFFF_FFFF});
      tick();
    end
    @(negedge clk_i);
    checks++;
    if ({err_timeout_o, call_count_o} !== {1'b1, 32'd1}) begin
      errors++;
      $display("FAIL to_fire got err %b count %0d exp 1 1", err_timeout_o, call_count_o);
    end
    repeat (3) tick();
    host_ret_valid_i = 1'b1;
    host_ret_data_i = 32'h77;
    tick();
    host_ret_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({err_timeout_o, call_count_o, rsp_valid_o, rsp_ret_o} !== {1'b1, 32'd1, 4'b0, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL to_late got err %b count %0d rsp %b ret %h exp 1 1 0000 ffffffff",
               err_timeout_o, call_count_o, rsp_valid_o, rsp_ret_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_spurious();
    test_reset_mid_wait();
`ifdef LOOM_DPI_TIMEOUT_EN
    test_timeout();
`endif
    wait_drain("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dpi_call_arbiter.md
Name: dpi_call_arbiter

Overview:
- Shares a single host DPI call channel among NUM_REQ DPI call sites in an emulated DUT.
- Arbitrates round-robin between requesters and forwards one call (function ID plus packed arguments) at a time.
- Waits for the host return value, then routes it back to the requester that made the call.
- Drives a stall request so the DUT clock can be frozen while a call is in flight, keeping DPI results cycle-accurate across scan dump and restore.

Parameters:
- NUM_REQ, 4, number of requesting call sites (2..16).
- FUNC_ID_W, 8, width of the DPI function identifier.
- ARG_W, 128, width of the packed argument bus (arrays are flattened by the caller).
- RET_W, 32, width of the return value.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only when the optional feature is enabled.

Ports:
- clk_i  in  1  single clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester call request; held until accepted.
- req_func_id_i  in  NUM_REQ*FUNC_ID_W  per-requester function ID; slice i belongs to requester i.
- req_args_i  in  NUM_REQ*ARG_W  per-requester packed arguments.
- req_ready_o  out  NUM_REQ  one-hot acceptance pulse.
- rsp_valid_o  out  NUM_REQ  one-hot return strobe, one cycle.
- rsp_ret_o  out  RET_W  return value, qualified by rsp_valid_o.
- host_call_valid_o  out  1  call presented to the host.
- host_call_ready_i  in  1  host accepts the call.
- host_call_func_id_o  out  FUNC_ID_W  latched function ID.
- host_call_args_o  out  ARG_W  latched arguments.
- host_call_src_o  out  $clog2(NUM_REQ)  index of the granted requester.
- host_ret_valid_i  in  1  host return strobe.
- host_ret_data_i  in  RET_W  host return value.
- stall_o  out  1  DUT clock-freeze request.
- call_count_o  out  32  completed-call counter.
- err_timeout_o  out  1  sticky watchdog error.

Behaviour:
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE.
  - Round-robin pointer is NUM_REQ-1, so requester 0 wins first.
  - Reset asserted mid-call aborts the call with no response; the host side must be flushed separately.
- FSM states: IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE.
- IDLE:
  - If any req_valid_i bit is set, grant the first set bit searching from pointer+1 with wrap-around.
  - req_ready_o[g] is driven combinationally in the same cycle.
  - Latch func_id, args and g; set pointer to g; go to ISSUE.
  - If no bit is set, stay in IDLE.
- ISSUE:
  - host_call_valid_o=1; func_id, args and src stay stable until host_call_ready_i=1, then go to WAIT.
  - No requester is accepted while ISSUE, WAIT or RESPOND is active.
- WAIT:
  - On host_ret_valid_i, latch host_ret_data_i and go to RESPOND.
  - host_ret_valid_i outside WAIT is ignored. This includes a return coincident with the ISSUE handshake.
- RESPOND:
  - rsp_valid_o[g]=1 and rsp_ret_o=latched data for exactly one cycle.
  - call_count_o increments, wrapping at 2^32.
  - Return to IDLE.
  - rsp_ret_o holds its value until the next RESPOND.
- Void functions complete identically: the host returns a don't-care value and the requester ignores it.
- stall_o = (state != IDLE), registered.
- Latency:
  - Request accepted in cycle 0 (IDLE).
  - host_call_valid_o first high in cycle 1.
  - Best case, with ready in cycle 1 and return in cycle 2: rsp_valid_o high in cycle 3.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,...
- A requester that drops req_valid_i before being granted is simply skipped; no call is issued for it.

Optional Feature:
- Macro: LOOM_DPI_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT and increments each cycle in WAIT.
  - When it reaches TIMEOUT_CYCLES without a return, err_timeout_o sets and stays set until reset.
  - The FSM then goes to RESPOND with rsp_ret_o = all ones; call_count_o still increments.
  - A late host return is ignored.
- When not defined: no counter exists, err_timeout_o is tied 0, and WAIT waits indefinitely.

Test Plan:
- Reset then single call: req_valid_i=4'b0001, func_id 8'h03, args[31:0]=32'hCAFE, host ready in cycle 1, return 32'hDAFE in cycle 2 -> req_ready_o=4'b0001 in cycle 0; host_call_src_o=0; rsp_valid_o=4'b0001 with rsp_ret_o=32'hDAFE in cycle 3; call_count_o=1; stall_o high in cycles 1-3.
- Round-robin: all four valid continuously, host returns immediately -> grant order 0,1,2,3,0,1; each call's return value equals 32'h100+index and reaches only its own requester.
- Host back-pressure: host_call_ready_i low for 5 cycles -> host_call_valid_o, func_id and args stay stable for all 5 cycles; rsp_valid_o only after the handshake plus return.
- Spurious return: host_ret_valid_i pulsed in IDLE and in ISSUE -> no rsp_valid_o and no count change; the later legal return 32'h42 is delivered.
- Reset mid-WAIT: rst_ni low while waiting -> all outputs 0 next cycle; a subsequent call from requester 2 is granted normally and call_count_o restarts at 0.
- Timeout (LOOM_DPI_TIMEOUT_EN, TIMEOUT_CYCLES=16): no host return -> after 16 WAIT cycles err_timeout_o=1 and rsp_ret_o=32'hFFFF_FFFF; a return 3 cycles later is ignored.
